// File: rtl/sig_deglitch.sv
// Purpose: synchronizes sig_in, passes only levels held STABLE_CYCLES samples, strobes edges and rejected glitches.
// Latency: sig_out and its edge strobe follow SYNC_STAGES + STABLE_CYCLES - 1 edges after a new level is first captured.
// Backpressure: none; free-running single-bit filter whose one-cycle strobes never stall.
module sig_deglitch #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sig_in,
    input  logic             clr_count,
    output logic             sig_out,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic             glitch_pulse,
    output logic [CNT_W-1:0] glitch_count
);
    // Stability counter only needs to reach STABLE_CYCLES-1.
    localparam int CB = $clog2(STABLE_CYCLES);
    localparam logic [CB-1:0] CNT_LAST = CB'(STABLE_CYCLES - 1);

    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_PENDING = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    state_t                 state_q, state_nxt;
    logic [CB-1:0]          cnt_q, cnt_nxt;
    logic                   out_nxt;
    logic                   rise_nxt;
    logic                   fall_nxt;
    logic                   glitch_nxt;
    logic [CNT_W-1:0]       count_nxt;

    // The synchronized level is the only view of sig_in the rest of the block gets.
    assign s = sync_q[SYNC_STAGES-1];

    // Metastability chain: shift the raw input through SYNC_STAGES flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
        end
    end

    // Qualification FSM: a differing level must persist STABLE_CYCLES edges, otherwise it is a glitch.
    always_comb begin
        state_nxt  = state_q;
        cnt_nxt    = '0;
        out_nxt    = sig_out;
        rise_nxt   = 1'b0;
        fall_nxt   = 1'b0;
        glitch_nxt = 1'b0;
        case (state_q)
            ST_STABLE: begin
                if (s != sig_out) begin
                    state_nxt = ST_PENDING;
                    cnt_nxt   = CB'(1);
                end
            end
            ST_PENDING: begin
                if (s == sig_out) begin
                    // Level fell back before qualifying: abandon and flag.
                    state_nxt  = ST_STABLE;
                    glitch_nxt = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_nxt = ST_STABLE;
                    out_nxt   = s;
                    rise_nxt  = s;
                    fall_nxt  = ~s;
                end else begin
                    cnt_nxt = cnt_q + 1'b1;
                end
            end
            default: begin
                state_nxt = ST_STABLE;
            end
        endcase
    end

    // Glitch counter: clear wins over increment, and the count sticks at all-ones.
    always_comb begin
        count_nxt = glitch_count;
        if (clr_count) begin
            count_nxt = '0;
        end else if (glitch_nxt && !(&glitch_count)) begin
            count_nxt = glitch_count + 1'b1;
        end
    end

    // State, filtered level, strobes and counter all update together on the clock edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_STABLE;
            cnt_q        <= '0;
            sig_out      <= 1'b0;
            rise_pulse   <= 1'b0;
            fall_pulse   <= 1'b0;
            glitch_pulse <= 1'b0;
            glitch_count <= '0;
        end else begin
            state_q      <= state_nxt;
            cnt_q        <= cnt_nxt;
            sig_out      <= out_nxt;
            rise_pulse   <= rise_nxt;
            fall_pulse   <= fall_nxt;
            glitch_pulse <= glitch_nxt;
            glitch_count <= count_nxt;
        end
    end

endmodule
